disk_track_writeback: RTL and testbench
=======================================

Name: disk_track_writeback

Overview:
- Write-back engine for the Disk II track buffer. It flushes a dirty 13-sector (6656-byte) track image from the track RAM to the mounted SD image through the hps_io sd_wr/sd_ack/sd_buff protocol.
- It is the write-direction companion of the existing track loader. The top level runs it before the loader fetches a new track.

Parameters:
- SECTORS, 13, 512-byte SD sectors per track.
- TRACK_W, 6, track number width.

Ports:
- clk_sys  in  1  system clock (14 MHz domain).
- reset_n  in  1  synchronous active-low reset.
- img_mounted  in  1  pulse: new image mounted on drive 0.
- img_present  in  1  mounted image size is non-zero.
- img_readonly  in  1  image is write-protected.
- track  in  TRACK_W  track currently held in the track RAM.
- dirty_set  in  1  pulse: the emulated drive wrote a byte into the track RAM.
- flush_req  in  1  pulse: request a flush (issued on track change or by the OSD).
- busy  out  1  flush in progress.
- done  out  1  one-cycle pulse when a request is completed.
- cpu_wait  out  1  stall the CPU while busy.
- dirty  out  1  track RAM holds unsaved data.
- sd_lba  out  32  SD sector address.
- sd_wr  out  1  write request to hps_io.
- sd_ack  in  1  hps_io acknowledge.
- sd_buff_addr  in  9  hps_io byte index within the sector.
- trk_ram_addr  out  13  track RAM read address.
- trk_ram_dout  in  8  track RAM read data (1-cycle latency).
- sd_buff_din  out  8  byte supplied to hps_io.

Behaviour:
- Reset values (while reset_n=0 at a clock edge): state IDLE, busy=0, done=0, cpu_wait=0, dirty=0, sd_wr=0, sd_lba=0, sector counter=0, abort flag=0.
- Data path, combinational:
  - trk_ram_addr = {sec[3:0], sd_buff_addr}.
  - sd_buff_din = trk_ram_dout.
  - hps_io tolerates the 1-cycle RAM latency.
- dirty:
  - Set by dirty_set when img_readonly=0; dirty_set is ignored when img_readonly=1.
  - Cleared on successful flush completion, on img_mounted, and on reset.
  - A dirty_set during a flush sets a pending flag. At completion dirty = pending, not 0.
- State IDLE:
  - On flush_req with dirty=1, img_present=1 and img_readonly=0:
    - latch trk_l = track;
    - sec = 0;
    - sd_lba = SECTORS*trk_l (zero-extended to 32 bits);
    - busy = cpu_wait = 1;
    - go to REQ.
  - On flush_req otherwise: done pulses on the next cycle; no SD traffic occurs.
- State REQ:
  - sd_wr=1.
  - On the sd_ack rising edge (registered old_ack=0, sd_ack=1): sd_wr=0, go to XFER.
- State XFER:
  - Wait for the sd_ack falling edge.
  - If abort is set, go to DONE and leave dirty cleared.
  - Else if sec == SECTORS-1, go to DONE.
  - Else sec += 1, sd_lba += 1, go to REQ.
- State DONE (one cycle):
  - busy = cpu_wait = 0;
  - done = 1;
  - dirty = pending (0 if aborted);
  - pending = 0;
  - go to IDLE.
- Simultaneous events and edge cases:
  - flush_req while busy: ignored. The requester must wait for done.
  - img_mounted while busy: sets abort. The current sector completes its handshake (sd_wr is never dropped mid-ack); no further sectors are written.
  - img_mounted together with dirty_set: img_mounted wins and dirty=0.
  - track changes during a flush: no effect, because trk_l is latched.
  - Reset mid-transfer: immediate return to IDLE with sd_wr=0; the partial image write is accepted.
- Latency:
  - flush_req to first sd_wr: 1 cycle.
  - Last sd_ack fall to done: 2 cycles.
- sd_lba arithmetic: track 35 gives 455 (0x1C7); the maximum is track 63, giving 819 to 831.

Test Plan:
- Writable image with dirty_set, track=3, flush_req; bench acks each sector after 600 cycles -> 13 sd_wr handshakes with sd_lba 39..51, cpu_wait high throughout, one done pulse, dirty=0; the bench captures sd_buff_din for sd_buff_addr 0..511 matching track RAM bytes {sec,addr}.
- flush_req with dirty=0 -> no sd_wr; done pulses exactly 2 cycles after flush_req; busy stays 0.
- img_readonly=1, dirty_set then flush_req -> dirty remains 0, no sd_wr, done pulse.
- dirty_set pulse during sector 5 of a flush to track 0 -> all 13 sectors (LBA 0..12) written, then dirty=1 after done.
- img_mounted during the sector 2 ack -> sector 2 handshake completes, no REQ for sector 3, done pulse, dirty=0, busy=0.
- reset_n=0 while sd_wr=1 in REQ for track 10 (sd_lba=130) -> next cycle sd_wr=0, busy=0, cpu_wait=0, dirty=0; a subsequent flush_req with dirty=0 only pulses done.

Source files
------------

// File: rtl/disk_track_writeback.sv
// Disk II track write-back engine: flushes a dirty 13-sector track image
// from the track RAM to the mounted SD image over the hps_io sd_wr/sd_ack protocol.
module disk_track_writeback #(
  parameter int SECTORS = 13,
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  input  logic [TRACK_W-1:0] track,
  input  logic               dirty_set,
  input  logic               flush_req,
  output logic               busy,
  output logic               done,
  output logic               cpu_wait,
  output logic               dirty,
  output logic [31:0]        sd_lba,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  output logic [12:0]        trk_ram_addr,
  input  logic [7:0]         trk_ram_dout,
  output logic [7:0]         sd_buff_din
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  localparam logic [3:0]  LAST  = 4'(SECTORS - 1);
  localparam logic [31:0] SEC32 = 32'(SECTORS);

  state_t     state;
  logic [3:0] sec;
  logic       old_ack;
  logic       pending;
  logic       abort;
  logic       ack_rise;
  logic       ack_fall;
  logic       hit;
  logic       go;

  assign ack_rise = sd_ack & ~old_ack;
  assign ack_fall = ~sd_ack & old_ack;
  // A drive write only counts on a writable image; a fresh mount wins.
  assign hit = dirty_set & ~img_readonly & ~img_mounted;
  assign go  = dirty & img_present & ~img_readonly & ~img_mounted;

  // hps_io reads the RAM directly; it absorbs the one-cycle RAM latency.
  assign trk_ram_addr = {sec, sd_buff_addr};
  assign sd_buff_din  = trk_ram_dout;

  // Flush sequencer with registered outputs, dirty and pending tracking
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_wait <= 1'b0;
      dirty    <= 1'b0;
      sd_wr    <= 1'b0;
      sd_lba   <= '0;
      sec      <= '0;
      old_ack  <= 1'b0;
      pending  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      old_ack <= sd_ack;
      done    <= 1'b0;

      if (img_mounted) begin
        dirty <= 1'b0;
      end else if (hit && !busy) begin
        dirty <= 1'b1;
      end

      if (busy) begin
        if (img_mounted) begin
          abort   <= 1'b1;
          pending <= 1'b0;
        end else if (hit) begin
          pending <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (flush_req) begin
            if (go) begin
              sec      <= '0;
              sd_lba   <= SEC32 * {{(32-TRACK_W){1'b0}}, track};
              busy     <= 1'b1;
              cpu_wait <= 1'b1;
              sd_wr    <= 1'b1;
              state    <= REQ;
            end else begin
              state <= DONE;
            end
          end
        end
        REQ: begin
          if (ack_rise) begin
            sd_wr <= 1'b0;
            state <= XFER;
          end
        end
        XFER: begin
          if (ack_fall) begin
            if (abort || img_mounted || sec == LAST) begin
              state <= DONE;
            end else begin
              sec    <= sec + 4'd1;
              sd_lba <= sd_lba + 32'd1;
              sd_wr  <= 1'b1;
              state  <= REQ;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_wait <= 1'b0;
          abort    <= 1'b0;
          pending  <= 1'b0;
          if (busy) begin
            dirty <= (pending | hit) & ~abort & ~img_mounted;
          end
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disk_track_writeback.sv
// Self-checking bench for disk_track_writeback: acts as hps_io host and
// track RAM, scoreboarding expected LBAs and sector bytes.
module tb_disk_track_writeback;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_present = 1'b1;
  logic        img_readonly = 1'b0;
  logic [5:0]  track = '0;
  logic        dirty_set = 1'b0;
  logic        flush_req = 1'b0;
  logic        busy;
  logic        done;
  logic        cpu_wait;
  logic        dirty;
  logic [31:0] sd_lba;
  logic        sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [12:0] trk_ram_addr;
  logic [7:0]  trk_ram_dout = '0;
  logic [7:0]  sd_buff_din;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_lba[$];
  logic [7:0]  q_data[$];

  disk_track_writeback #(.SECTORS(13), .TRACK_W(6)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .img_mounted  (img_mounted),
    .img_present  (img_present),
    .img_readonly (img_readonly),
    .track        (track),
    .dirty_set    (dirty_set),
    .flush_req    (flush_req),
    .busy         (busy),
    .done         (done),
    .cpu_wait     (cpu_wait),
    .dirty        (dirty),
    .sd_lba       (sd_lba),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .trk_ram_addr (trk_ram_addr),
    .trk_ram_dout (trk_ram_dout),
    .sd_buff_din  (sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] ram_byte(input logic [12:0] a);
    return a[7:0] ^ {a[12:9], a[8], a[12:10]} ^ 8'h5A;
  endfunction

  // Track RAM model with one-cycle read latency
  always @(posedge clk_sys) trk_ram_dout <= ram_byte(trk_ram_addr);

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_dirty();
    dirty_set = 1'b1;
    @(negedge clk_sys);
    dirty_set = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic serve_sector(input int secno, input int delay,
                              input int mount_at, input int dset_at,
                              output bit ok);
    int n = 0;
    logic [31:0] el;
    logic [7:0]  ed;
    logic [12:0] ba;
    ok = 1'b0;
    while (sd_wr !== 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (sd_wr !== 1'b1) begin
      errors++;
      $display("FAIL sd_wr_wait sec %0d: sd_wr=%b required 1", secno, sd_wr);
      return;
    end
    checks++;
    if (q_lba.size() == 0) begin
      errors++;
      $display("FAIL lba_extra sec %0d: sd_lba=%0d required none", secno, sd_lba);
      return;
    end
    el = q_lba.pop_front();
    if (sd_lba !== el) begin
      errors++;
      $display("FAIL lba sec %0d: got %0d required %0d", secno, sd_lba, el);
    end
    checks++;
    if (cpu_wait !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL wait_flags sec %0d: cpu_wait=%b done=%b required 1 0", secno, cpu_wait, done);
    end
    repeat (delay) @(negedge clk_sys);
    checks++;
    if (sd_wr !== 1'b1) begin
      errors++;
      $display("FAIL sd_wr_hold sec %0d: got %b required 1", secno, sd_wr);
    end
    sd_ack = 1'b1;
    sd_buff_addr = 9'd0;
    ba = {secno[3:0], 9'd0};
    q_data.push_back(ram_byte(ba));
    for (int a = 1; a <= 512; a++) begin
      @(negedge clk_sys);
      if (a == 1) begin
        checks++;
        if (sd_wr !== 1'b0) begin
          errors++;
          $display("FAIL sd_wr_drop sec %0d: got %b required 0", secno, sd_wr);
        end
      end
      ed = q_data.pop_front();
      checks++;
      if (sd_buff_din !== ed) begin
        errors++;
        $display("FAIL data sec %0d addr %0d: got %h required %h", secno, a - 1, sd_buff_din, ed);
      end
      img_mounted = (a == mount_at);
      dirty_set = (a == dset_at);
      if (a < 512) begin
        sd_buff_addr = a[8:0];
        ba = {secno[3:0], a[8:0]};
        q_data.push_back(ram_byte(ba));
      end
    end
    img_mounted = 1'b0;
    dirty_set = 1'b0;
    sd_ack = 1'b0;
    sd_buff_addr = 9'd0;
    ok = 1'b1;
  endtask

  task automatic run_flush(input int trk, input int nsec, input int delay,
                           input int mount_sec, input int dset_sec,
                           input int new_trk);
    bit ok;
    for (int s = 0; s < nsec; s++) q_lba.push_back(32'(13 * trk + s));
    track = trk[5:0];
    flush_req = 1'b1;
    @(negedge clk_sys);
    flush_req = 1'b0;
    track = new_trk[5:0];
    checks++;
    if (sd_wr !== 1'b1 || busy !== 1'b1 || cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL start trk %0d: sd_wr=%b busy=%b cpu_wait=%b required 1 1 1", trk, sd_wr, busy, cpu_wait);
    end
    for (int s = 0; s < nsec; s++) begin
      serve_sector(s, delay, (s == mount_sec) ? 100 : -1,
                   (s == dset_sec) ? 100 : -1, ok);
      if (!ok) break;
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL end_gap trk %0d: done=%b sd_wr=%b required 0 0", trk, done, sd_wr);
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_wait !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL end_done trk %0d: done=%b busy=%b cpu_wait=%b sd_wr=%b required 1 0 0 0", trk, done, busy, cpu_wait, sd_wr);
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b0 || q_lba.size() != 0) begin
      errors++;
      $display("FAIL end_pulse trk %0d: done=%b lba_left=%0d required 0 0", trk, done, q_lba.size());
    end
    q_lba.delete();
  endtask

  task automatic skip_flush(input string tag);
    flush_req = 1'b1;
    @(negedge clk_sys);
    flush_req = 1'b0;
    checks++;
    if (done !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_c1: done=%b sd_wr=%b busy=%b required 0 0 0", tag, done, sd_wr, busy);
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b1 || sd_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_c2: done=%b sd_wr=%b busy=%b required 1 0 0", tag, done, sd_wr, busy);
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL %s_c3: done=%b sd_wr=%b required 0 0", tag, done, sd_wr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({busy, done, cpu_wait, dirty, sd_wr} !== 5'b0 || sd_lba !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b cpu_wait=%b dirty=%b sd_wr=%b lba=%0d required all 0",
               busy, done, cpu_wait, dirty, sd_wr, sd_lba);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_full_flush();
    pulse_dirty();
    checks++;
    if (dirty !== 1'b1) begin
      errors++;
      $display("FAIL dirty_set: dirty=%b required 1", dirty);
    end
    run_flush(3, 13, 600, -1, -1, 9);
    checks++;
    if (dirty !== 1'b0) begin
      errors++;
      $display("FAIL full_dirty: dirty=%b required 0", dirty);
    end
  endtask

  task automatic test_clean_flush();
    skip_flush("clean");
    checks++;
    if (dirty !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_state: dirty=%b busy=%b required 0 0", dirty, busy);
    end
  endtask

  task automatic test_readonly();
    img_readonly = 1'b1;
    pulse_dirty();
    checks++;
    if (dirty !== 1'b0) begin
      errors++;
      $display("FAIL ro_dirty: dirty=%b required 0", dirty);
    end
    skip_flush("ro");
    img_readonly = 1'b0;
  endtask

  task automatic test_pending();
    pulse_dirty();
    run_flush(0, 13, 3, -1, 5, 0);
    checks++;
    if (dirty !== 1'b1) begin
      errors++;
      $display("FAIL pending_dirty: dirty=%b required 1", dirty);
    end
  endtask

  task automatic test_abort();
    pulse_dirty();
    run_flush(20, 3, 3, 2, -1, 20);
    repeat (5) @(negedge clk_sys);
    checks++;
    if (dirty !== 1'b0 || busy !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: dirty=%b busy=%b sd_wr=%b required 0 0 0", dirty, busy, sd_wr);
    end
  endtask

  task automatic test_reset_mid();
    pulse_dirty();
    track = 6'd10;
    flush_req = 1'b1;
    @(negedge clk_sys);
    flush_req = 1'b0;
    checks++;
    if (sd_wr !== 1'b1 || sd_lba !== 32'd130) begin
      errors++;
      $display("FAIL rst_req: sd_wr=%b lba=%0d required 1 130", sd_wr, sd_lba);
    end
    reset_n = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({sd_wr, busy, cpu_wait, dirty} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid: sd_wr=%b busy=%b cpu_wait=%b dirty=%b required 0 0 0 0",
               sd_wr, busy, cpu_wait, dirty);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    skip_flush("post_rst");
  endtask

  initial begin
    test_reset();
    test_full_flush();
    test_clean_flush();
    test_readonly();
    test_pending();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
